prog_loader: RTL and testbench

Boot-time program loader for the pipelined `cpu`. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them into the CPU's instruction memory write port, then checks an XOR checksum. It holds the CPU in reset until a load verifies, then releases it. It is the writer side of the instruction memory that the CPU fetch stage reads.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/word_packer.sv | 50 +++++
 rtl/prog_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU/loader definitions: memory geometry defaults, loader FSM states
// and the count-byte validity helper.
package cpu_pkg;

  localparam int WIDTH    = 32;
  localparam int MEM_SIZE = 32;
  localparam int ADDR_W   = $clog2(MEM_SIZE);
  localparam int BYTE_W   = 8;
  localparam int LANES    = 4;

  typedef enum logic [2:0] {
    LD_LOAD_CNT  = 3'd0,
    LD_LOAD_BYTE = 3'd1,
    LD_WRITE     = 3'd2,
    LD_CHECK     = 3'd3,
    LD_RUN       = 3'd4,
    LD_ERR       = 3'd5
  } loader_state_t;

  // A count byte is usable only when it names at least one word and fits memory.
  function automatic logic count_ok(input logic [7:0] n, input int unsigned mem_size);
    return (n != 8'd0) && ({24'd0, n} <= mem_size);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian words from a byte stream: each loaded byte lands in
// the current lane, the lane index advances and wraps, and a full flag marks
// that the top lane has just been filled.
module word_packer #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_load,
  input  logic [BYTE_W-1:0]         i_byte,
  output logic [LANES*BYTE_W-1:0]   o_word,
  output logic [LANE_W-1:0]         o_lane,
  output logic                      o_full
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANES*BYTE_W-1:0] r_word;
  logic [LANE_W-1:0]       r_lane;
  logic                    r_full;

  // Byte lane write, lane advance and full tracking; the assembled word is
  // held untouched between loads so it stays stable during the memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_lane <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_lane <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      for (int li = 0; li < LANES; li++) begin
        if (r_lane == LANE_W'(li)) begin
          r_word[li*BYTE_W +: BYTE_W] <= i_byte;
        end
      end
      r_lane <= r_lane + LANE_W'(1);
      r_full <= (r_lane == LAST_LANE);
    end
  end

  assign o_word = r_word;
  assign o_lane = r_lane;
  assign o_full = r_full;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives count, data and checksum bytes over a
// valid/ready stream, writes assembled words to instruction memory, verifies
// an XOR checksum and holds the CPU in reset until a load verifies.
module prog_loader #(
  parameter int WIDTH    = cpu_pkg::WIDTH,
  parameter int MEM_SIZE = cpu_pkg::MEM_SIZE,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  input  logic              reload
);

  import cpu_pkg::*;

  localparam int NLANES = WIDTH / BYTE_W;
  localparam int LANE_W = $clog2(NLANES);
  // One extra bit so the word index can reach N == MEM_SIZE without wrapping.
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANES - 1);

  loader_state_t     r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_word_idx;
  logic [7:0]        r_acc;
  logic              r_mem_we;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_xfer;
  logic              w_cnt_ok;
  logic              w_pack_clear;
  logic              w_pack_load;
  logic [WIDTH-1:0]  w_word;
  logic [LANE_W-1:0] w_lane;
  logic              w_full;
  logic [CNT_W-1:0]  w_idx_next;

  // Ready is a pure state decode so it never depends on in_valid.
  assign w_ready = (r_state == LD_LOAD_CNT) ||
                   (r_state == LD_LOAD_BYTE) ||
                   (r_state == LD_CHECK);
  assign w_xfer       = in_valid & w_ready;
  assign w_cnt_ok     = count_ok(in_data, MEM_SIZE);
  assign w_pack_clear = w_xfer && (r_state == LD_LOAD_CNT) && w_cnt_ok;
  assign w_pack_load  = w_xfer && (r_state == LD_LOAD_BYTE);
  assign w_idx_next   = r_word_idx + CNT_ONE;

  word_packer #(
    .LANES  (NLANES),
    .BYTE_W (BYTE_W),
    .LANE_W (LANE_W)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (w_pack_clear),
    .i_load  (w_pack_load),
    .i_byte  (in_data),
    .o_word  (w_word),
    .o_lane  (w_lane),
    .o_full  (w_full)
  );

  // Loader FSM with counters, checksum accumulator and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LD_LOAD_CNT;
      r_count    <= '0;
      r_word_idx <= '0;
      r_acc      <= '0;
      r_mem_we   <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        LD_LOAD_CNT: begin
          if (w_xfer) begin
            if (w_cnt_ok) begin
              r_count    <= in_data[CNT_W-1:0];
              r_word_idx <= '0;
              r_acc      <= '0;
              r_state    <= LD_LOAD_BYTE;
            end else begin
              r_err   <= 1'b1;
              r_state <= LD_ERR;
            end
          end
        end
        LD_LOAD_BYTE: begin
          if (w_xfer) begin
            r_acc <= r_acc ^ in_data;
            // The byte being accepted fills the top lane: the word is complete.
            if (w_lane == LAST_LANE) begin
              r_mem_we <= 1'b1;
              r_state  <= LD_WRITE;
            end
          end
        end
        LD_WRITE: begin
          r_mem_we   <= 1'b0;
          r_word_idx <= w_idx_next;
          if (w_idx_next == r_count) begin
            r_state <= LD_CHECK;
          end else begin
            r_state <= LD_LOAD_BYTE;
          end
        end
        LD_CHECK: begin
          if (w_xfer) begin
            if (in_data == r_acc) begin
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= LD_RUN;
            end else begin
              r_err   <= 1'b1;
              r_state <= LD_ERR;
            end
          end
        end
        LD_RUN, LD_ERR: begin
          if (reload) begin
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= LD_LOAD_CNT;
          end
        end
        default: begin
          r_state <= LD_LOAD_CNT;
        end
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_word_idx[ADDR_W-1:0];
  assign mem_wdata = w_word;
  assign cpu_rst   = r_cpu_rst;
  assign done      = r_done;
  assign err       = r_err;

  // The full flag mirrors the WRITE entry; it is kept for observability only.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader with a stream-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;
  logic        in_ready, mem_we, cpu_rst, done, err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err),
    .reload    (reload)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          we_count = 0;
  logic [36:0] cap_q[$];
  logic [36:0] save_q[$];
  logic [7:0]  stream_q[$];
  int          pulse_at = -1;
  bit          gaps = 0;

  // Write-port monitor: every strobe cycle is captured as {addr, data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      cap_q.push_back({mem_addr, mem_wdata});
      $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one byte until it is accepted (optionally with random idle cycles).
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    rdy = 0;
    for (int k = 0; k < 200 && !rdy; k++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        continue;
      end
      in_valid = 1'b1;
      in_data  = b;
      rdy      = in_ready;
      @(posedge clk);
    end
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reload(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cpurst"}, {31'd0, cpu_rst}, 32'd1);
  endtask

  // Build count, n random words and a checksum (corrupted when bad is set).
  task automatic build_stream(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      x ^= b;
    end
    stream_q.push_back(bad ? ~x : x);
  endtask

  // Drive stream_q and check every write and the final outcome against the model.
  task automatic run_load(input string tag);
    int          n;
    int          base;
    logic [31:0] exp_word;
    logic [7:0]  x;
    logic [7:0]  cs;
    n = int'(stream_q[0]);
    base = we_count;
    $display("load %s count=%0d bytes=%0d", tag, n, stream_q.size());
    send_byte(stream_q[0]);
    if (n == 0 || n > 32) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_cnt_err"}, {31'd0, err}, 32'd1);
      chk({tag, "_cnt_cpurst"}, {31'd0, cpu_rst}, 32'd1);
      chk({tag, "_cnt_rdy"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_cnt_nowe"}, 32'(we_count), 32'(base));
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      for (int l = 0; l < 4; l++) begin
        if (pulse_at == 4 * w + l) pulse_reload_ignored(tag);
        send_byte(stream_q[1 + 4 * w + l]);
        x ^= stream_q[1 + 4 * w + l];
      end
      @(negedge clk);
      in_valid = 1'b0;
      exp_word = {stream_q[4*w+4], stream_q[4*w+3], stream_q[4*w+2], stream_q[4*w+1]};
      chk($sformatf("%s_we%0d", tag, w), {31'd0, mem_we}, 32'd1);
      chk($sformatf("%s_addr%0d", tag, w), {27'd0, mem_addr}, 32'(w));
      chk($sformatf("%s_data%0d", tag, w), mem_wdata, exp_word);
      chk($sformatf("%s_rdy_wr%0d", tag, w), {31'd0, in_ready}, 32'd0);
    end
    cs = stream_q[4 * n + 1];
    chk({tag, "_hold"}, {31'd0, cpu_rst}, 32'd1);
    send_byte(cs);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, (cs == x) ? 32'd1 : 32'd0);
    chk({tag, "_err"}, {31'd0, err}, (cs == x) ? 32'd0 : 32'd1);
    chk({tag, "_cpurst"}, {31'd0, cpu_rst}, (cs == x) ? 32'd0 : 32'd1);
    chk({tag, "_nwrites"}, 32'(we_count - base), 32'(n));
  endtask

  // Reload while loading must change nothing visible.
  task automatic pulse_reload_ignored(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, "_ign_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ign_cpurst"}, {31'd0, cpu_rst}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, {27'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpurst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int same;
    logic [7:0] x;

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;

    // Known program: two words, good checksum computed from the data bytes
    stream_q = '{8'd2, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00, 8'h00};
    x = 8'h00;
    for (int i = 1; i <= 8; i++) x ^= stream_q[i];
    stream_q[9] = x;
    run_load("prog2");
    pulse_reload("reload_run");

    // Same program, corrupt checksum
    stream_q[9] = 8'hFF;
    run_load("badcs");
    pulse_reload("reload_err");

    // Out-of-range count bytes
    stream_q = '{8'd0};
    run_load("cnt0");
    pulse_reload("reload_cnt0");
    stream_q = '{8'd33};
    run_load("cnt33");
    pulse_reload("reload_cnt33");

    // Full memory, gap-free then with 50% valid gaps; both captures must match
    build_stream(32, 1'b0);
    gaps = 0;
    cap_q.delete();
    run_load("full_nogap");
    save_q = cap_q;
    pulse_reload("reload_full");
    gaps = 1;
    cap_q.delete();
    run_load("full_gap");
    gaps = 0;
    same = (cap_q.size() == save_q.size()) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < save_q.size(); i++)
      if (cap_q[i] !== save_q[i]) same = 0;
    chk("gap_vs_nogap", 32'(same), 32'd1);
    chk("gap_nwrites", 32'(cap_q.size()), 32'd32);
    pulse_reload("reload_full2");

    // Asynchronous reset in the middle of a load (during the first WRITE)
    build_stream(2, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(stream_q[i]);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    build_stream(2, 1'b0);
    run_load("after_rst");
    pulse_reload("reload_after_rst");

    // Reload pulsed during LOAD_BYTE is ignored
    build_stream(3, 1'b0);
    pulse_at = 2;
    run_load("reload_ign");
    pulse_at = -1;
    pulse_reload("reload_ign_end");

    // Random loads, some with corrupted checksums
    for (int t = 0; t < 4; t++) begin
      build_stream($urandom_range(1, 32), ($urandom_range(0, 3) == 0));
      gaps = bit'($urandom_range(0, 1));
      run_load($sformatf("rnd%0d", t));
      gaps = 0;
      pulse_reload($sformatf("reload_rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
